// File: rtl/hold_piece_manager.sv
// Hold-slot owner for the falling tetromino: detects hold presses, swaps the live piece
// into the slot and drives the respawn handshake, allowing at most one hold per drop.
package hold_piece_pkg;
    typedef enum logic [2:0] {
        BLANK = 3'd0,
        I     = 3'd1,
        O     = 3'd2,
        T     = 3'd3,
        S     = 3'd4,
        Z     = 3'd5,
        J     = 3'd6,
        L     = 3'd7
    } tile_type_t;
endpackage

module hold_piece_manager
    import hold_piece_pkg::*;
#(
    parameter int unsigned COUNT_W   = 8,
    parameter bit          HOLD_ONCE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_start,
    input  logic               hold_key,
    input  logic               falling_valid,
    input  tile_type_t         falling_type,
    input  logic               piece_locked,
    input  logic               spawn_ack,
    output tile_type_t         hold_piece_type,
    output logic               spawn_req,
    output logic               spawn_from_hold,
    output tile_type_t         spawn_type,
    output logic               hold_allowed,
    output logic               busy,
    output logic [COUNT_W-1:0] hold_count
);

    typedef enum logic [1:0] {StIdle, StReqNext, StReqSwap} state_t;

    state_t             state_q, state_d;
    logic               key_prev_q;
    tile_type_t         slot_q, slot_d;
    tile_type_t         spawn_type_q, spawn_type_d;
    logic               allowed_q, allowed_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               hold_edge;
    logic               accept;

    assign hold_edge = hold_key & ~key_prev_q;

    assign busy            = (state_q != StIdle);
    assign spawn_req       = busy;
    assign spawn_from_hold = (state_q == StReqSwap);
    assign spawn_type      = spawn_type_q;
    assign hold_piece_type = slot_q;
    assign hold_count      = count_q;
    assign hold_allowed    = HOLD_ONCE ? (allowed_q & ~busy) : ~busy;

    // A lock in the same cycle as the press wins over the hold
    assign accept = (state_q == StIdle) & hold_edge & hold_allowed & falling_valid &
                    ~piece_locked;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        spawn_type_d = spawn_type_q;
        allowed_d    = allowed_q;
        count_d      = count_q;

        if (game_start) begin
            state_d      = StIdle;
            slot_d       = BLANK;
            spawn_type_d = BLANK;
            allowed_d    = 1'b1;
            count_d      = '0;
        end else begin
            if (piece_locked) begin
                allowed_d = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d      = (slot_q == BLANK) ? StReqNext : StReqSwap;
                        spawn_type_d = slot_q;
                        slot_d       = falling_type;
                        if (HOLD_ONCE) begin
                            allowed_d = 1'b0;
                        end
                        if (count_q != '1) begin
                            count_d = count_q + COUNT_W'(1);
                        end
                    end
                end
                StReqNext, StReqSwap: begin
                    if (spawn_ack) begin
                        state_d      = StIdle;
                        spawn_type_d = BLANK;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            key_prev_q   <= 1'b1;
            slot_q       <= BLANK;
            spawn_type_q <= BLANK;
            allowed_q    <= 1'b1;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            key_prev_q   <= hold_key;
            slot_q       <= slot_d;
            spawn_type_q <= spawn_type_d;
            allowed_q    <= allowed_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: doc/hold_piece_manager.md
# hold_piece_manager

Sequential owner of the hold slot. Detects hold-key presses, captures the falling tetromino into the hold slot, and requests a respawn from either the next-piece queue or the previously held piece. Enforces one hold per drop. It sits between input handling, the falling-piece/spawn logic and the hold-region pixel driver, which consumes `hold_piece_type`.

## Interface
Parameters:
- `COUNT_W`, 8: width of the saturating hold-event counter.
- `HOLD_ONCE`, 1: when 1, only one hold is allowed per dropped piece. When 0, holds are unlimited, but each must still be separated by a completed spawn handshake.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `game_start`  in  1  synchronous clear to reset state. Takes priority over every other input except `rst`.
- `hold_key`  in  1  level from the debounced hold button. Only its rising edge is used.
- `falling_valid`  in  1  a falling piece is live and may be held.
- `falling_type`  in  `tile_type_t`  type of the live falling piece.
- `piece_locked`  in  1  one-cycle pulse when the falling piece locks into the playfield.
- `spawn_ack`  in  1  spawner accepted the current request.
- `hold_piece_type`  out  `tile_type_t`  contents of the hold slot. `BLANK` when empty.
- `spawn_req`  out  1  request that the spawner replace the falling piece.
- `spawn_from_hold`  out  1  qualifies `spawn_req`:
  - 1: spawn `spawn_type`.
  - 0: pop the next-piece queue.
- `spawn_type`  out  `tile_type_t`  piece to spawn when `spawn_from_hold`=1. Otherwise `BLANK`.
- `hold_allowed`  out  1  a hold would currently be accepted. Used by the UI to dim the hold box.
- `busy`  out  1  a spawn handshake is outstanding.
- `hold_count`  out  `COUNT_W`  number of accepted holds since reset or `game_start`. Saturates at all-ones.

## Operation
- Edge detect: `key_prev` register, reset value 1, so a key held through reset does not fire. `hold_edge` = `hold_key` & ~`key_prev`.
- FSM states: IDLE, REQ_NEXT, REQ_SWAP.
- IDLE to REQ_NEXT:
  - Condition: `hold_edge` & `hold_allowed` & `falling_valid` & ~`piece_locked`, with the slot `BLANK`.
  - Register `hold_piece_type`←`falling_type`.
  - Assert `spawn_req`=1 and `spawn_from_hold`=0.
- IDLE to REQ_SWAP:
  - Same condition, with the slot non-`BLANK`.
  - Register `spawn_type`←old `hold_piece_type` and `hold_piece_type`←`falling_type`.
  - Assert `spawn_req`=1 and `spawn_from_hold`=1.
- On either accepted hold:
  - If `HOLD_ONCE`, clear `hold_allowed`.
  - Increment `hold_count`, saturating.
- REQ_NEXT / REQ_SWAP to IDLE on `spawn_ack`:
  - Deassert `spawn_req`.
  - Clear `spawn_from_hold`.
  - Set `spawn_type`←`BLANK`.
- Hold edges that arrive outside IDLE, or while the hold is not allowed, are dropped, not queued.
- `piece_locked` sets `hold_allowed`=1 in any state.
- `hold_allowed` output:
  - `HOLD_ONCE`=1: the registered flag, forced to 0 while `busy`.
  - `HOLD_ONCE`=0: `~busy`.
- `busy` = (state ≠ IDLE).
- `game_start` results:
  - state→IDLE, slot→`BLANK`, `spawn_req`→0.
  - `hold_allowed`→1, `hold_count`→0.
  - `key_prev` is still updated normally.

## Timing
- Reset values:
  - `hold_piece_type`=`BLANK`, `spawn_type`=`BLANK`.
  - `spawn_req`=0, `spawn_from_hold`=0.
  - `hold_allowed`=1, `busy`=0, `hold_count`=0.
  - state IDLE, `key_prev`=1.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- Latency: rising edge of `hold_key` sampled at edge N. At edge N+1, `spawn_req`, `hold_piece_type` and `busy` update together.
- Handshake: `spawn_req`, `spawn_from_hold` and `spawn_type` are held stable until `spawn_ack` is sampled high. They drop at the following edge.
  - `spawn_ack` may arrive in the first request cycle; minimum request width is 1 cycle.
  - `spawn_ack` while idle is ignored.
- Simultaneous `piece_locked` and `hold_edge` in IDLE: the lock wins. The hold is ignored and `hold_allowed` is set.
- `piece_locked` while busy: it sets the allowed flag, but the flag is only visible on `hold_allowed` after `spawn_ack`. The handshake continues.
- Async `rst` mid-handshake: all outputs take reset values immediately; no `spawn_ack` is expected afterwards.

## Test plan
- First hold:
  - Stimulus: reset, `falling_type`=T, `falling_valid`=1, pulse `hold_key`.
  - Required response: one cycle later `hold_piece_type`=T, `spawn_req`=1, `spawn_from_hold`=0, `busy`=1.
  - Then assert `spawn_ack`: one cycle later `spawn_req`=0, `hold_allowed`=0, `hold_count`=1.
- Swap:
  - Stimulus: from the previous state, pulse `piece_locked`, set `falling_type`=I, press `hold_key`.
  - Required response: `spawn_from_hold`=1, `spawn_type`=T, `hold_piece_type`=I, `hold_count`=2.
- Lockout:
  - Stimulus: `HOLD_ONCE`=1, after a completed hold, press `hold_key` 3 times with no `piece_locked`.
  - Required response: no `spawn_req`, slot unchanged, `hold_count` unchanged.
- Simultaneous events and held key:
  - Stimulus A: `piece_locked` and a `hold_key` edge in the same cycle.
  - Required response A: no request, `hold_allowed`=1.
  - Stimulus B: `hold_key` held high across reset deassertion.
  - Required response B: no request until the key is released and re-pressed.
- Restart and reset:
  - Stimulus A: `game_start` while in REQ_SWAP.
  - Required response A: next cycle IDLE, slot `BLANK`, `spawn_req`=0, `hold_count`=0.
  - Stimulus B: async `rst` mid-cycle.
  - Required response B: outputs reach reset values before the next clock edge.
- Saturation:
  - Stimulus: `COUNT_W`=2, `HOLD_ONCE`=0, perform 5 acked holds.
  - Required response: `hold_count` stops at 3.
